operand_mux_pipe: RTL and testbench
===================================

Name: operand_mux_pipe

Overview:
Parametrised, pipelined successor to the single-stage ALU operand-B select mux. Selects one of NUM_SRC operand sources: register data, sign-extended immediate, EX/MEM forward, MEM/WB forward. Registers the result behind a valid/ready handshake with a 2-entry skid buffer, so the ID/EX boundary can stall or flush without losing operands. Sits between decode/forwarding logic and the ALU input register.

Parameters:
WIDTH, 64, operand width in bits.
NUM_SRC, 4, number of selectable sources (legal range 2..16).
SEL_W, $clog2(NUM_SRC), select width. Derived locally and never overridden.

Ports:
clk  input  1  rising-edge clock.
reset  input  1  synchronous, active-high reset.
in_data  input  NUM_SRC*WIDTH  flattened sources; source i occupies [i*WIDTH +: WIDTH].
in_sel  input  SEL_W  source index; 0 = register data, 1 = sign-extended immediate.
in_valid  input  1  upstream beat valid.
in_ready  output  1  block can accept a beat this cycle.
flush  input  1  discard all held beats.
out_data  output  WIDTH  selected operand.
out_err  output  1  beat was produced from an out-of-range select.
out_valid  output  1  out_data/out_err valid.
out_ready  input  1  downstream accepts a beat.

Behaviour:
- Reset values, applied synchronously while reset=1:
  - out_valid=0, out_data=0, out_err=0.
  - Skid entry empty; in_ready=1 from the first cycle after reset deasserts.
  - Reset overrides flush and any handshake in the same cycle.
- Handshake terms:
  - Accept = in_valid & in_ready.
  - Drain = out_valid & out_ready.
  - in_valid/in_sel/in_data are sampled only on accept.
- Select:
  - in_sel < NUM_SRC: data = source[in_sel], err=0.
  - in_sel >= NUM_SRC: data = 0, err=1. The beat is still transferred, never dropped.
- Latency: an accepted beat appears on out_data with out_valid=1 on the next clock edge when the output stage is empty or draining.
- Throughput: one beat per cycle while out_ready=1.
- Storage: output register (O) plus one skid register (S). in_ready is registered and equals !S_valid.
- Per-cycle transitions (no flush):
  - O empty, accept: O <= beat.
  - O full, drain, accept, S empty: O <= beat.
  - O full, drain, S full: O <= S, S empty; in_ready was 0, so no accept.
  - O full, no drain, accept: S <= beat; in_ready=0 next cycle.
  - O full, drain, no accept, S empty: O empty.
- Invariants:
  - O and S preserve arrival order.
  - out_data/out_err are stable while out_valid=1 and out_ready=0.
  - out_data holds its last value when out_valid=0; it is not forced to zero.
- Flush (synchronous, one cycle):
  - Next cycle: O and S empty, out_valid=0, in_ready=1.
  - A beat presented with in_valid in the flush cycle is discarded.
  - A drain in the flush cycle still completes, since downstream saw valid&ready.
- Simultaneous accept and drain with S full cannot occur (in_ready=0).
- NUM_SRC a power of two: out_err is unreachable and stays 0.

Decomposition:
- Shared package (datapath_pkg):
  - Source-index constants SRC_REG=0, SRC_IMM=1, SRC_FWD_EXMEM=2, SRC_FWD_MEMWB=3.
  - Default OPERAND_W=64.
- Sub-module skid_buffer (WIDTH+1 bits: data plus err) holds the O/S handshake logic and is reusable at other pipeline boundaries.
- The select and range check stay in the top as combinational logic feeding skid_buffer.

Test Plan:
- Basic select, reset released, out_ready=1: srcs {0x1111, 0xFFFF_FFFF_FFFF_FFF0, 0x3333, 0x4444}, sel=1 for one beat -> next cycle out_valid=1, out_data=0xFFFF_FFFF_FFFF_FFF0, out_err=0.
- Backpressure: out_ready=0, three consecutive beats with sel=0,2,3 -> beats 1 and 2 accepted; in_ready=0 from cycle 3 so beat 3 is held upstream. Raise out_ready -> outputs 0x1111, 0x3333, then 0x4444, in order, none lost or duplicated.
- Out-of-range: NUM_SRC=3, sel=3 -> out_data=0, out_err=1. Next beat with sel=2 -> out_err=0.
- Flush with O and S full, plus in_valid in the same cycle -> next cycle out_valid=0, in_ready=1. The flush-cycle beat never appears on out_data.
- Reset mid-operation: O and S full, out_ready=0, assert reset for 1 cycle -> out_valid=0, out_data=0, out_err=0. in_ready=1 the following cycle, and a new beat passes with 1-cycle latency.
- Streaming: 100 random beats, random sel in range, in_valid=out_ready=1 -> one beat per cycle after 1-cycle fill, data matches scoreboard. Repeat with random out_ready and check ordering and no loss.

Source files
------------

// File: rtl/datapath_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : datapath_pkg
//  Description : Shared datapath constants for the operand-select pipeline.
//                Source-index encodings used by decode/forwarding logic and
//                the default operand width.
//  Revision    : 1.0 - initial release
// ============================================================================
package datapath_pkg;

    // Operand-B source indices as seen on in_sel
    localparam int SRC_REG       = 0;
    localparam int SRC_IMM       = 1;
    localparam int SRC_FWD_EXMEM = 2;
    localparam int SRC_FWD_MEMWB = 3;

    // Default operand width
    localparam int OPERAND_W     = 64;

endpackage
`default_nettype wire

// File: rtl/skid_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : skid_buffer
//  Description : Valid/ready pipeline register with a single skid entry.
//                Output register O feeds out_*; skid register S catches one
//                beat when downstream stalls. in_ready is !S_valid, so it
//                is driven purely from state.
//  Ports       : clk, reset         - clock, synchronous active-high reset
//                in_data/valid/ready - upstream handshake
//                flush               - drop every held beat next cycle
//                out_data/valid/ready- downstream handshake
//  Revision    : 1.0 - initial release
// ============================================================================
module skid_buffer #(
    parameter int DATA_W = 65
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              flush,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready
);

    logic [DATA_W-1:0] r_o_data;
    logic              r_o_valid;
    logic [DATA_W-1:0] r_s_data;
    logic              r_s_valid;

    logic w_accept;
    logic w_drain;

    assign in_ready  = ~r_s_valid;
    assign out_data  = r_o_data;
    assign out_valid = r_o_valid;

    assign w_accept  = in_valid & ~r_s_valid;
    assign w_drain   = r_o_valid & out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_o_data  <= '0;
            r_o_valid <= 1'b0;
            r_s_data  <= '0;
            r_s_valid <= 1'b0;
        end else if (flush) begin
            // Any drain this cycle has already completed downstream; the
            // upstream beat, if any, is simply not captured.
            r_o_valid <= 1'b0;
            r_s_valid <= 1'b0;
        end else if (!r_o_valid || w_drain) begin
            // Output slot frees up: the skid entry is older, so it goes first.
            if (r_s_valid) begin
                r_o_data  <= r_s_data;
                r_s_valid <= 1'b0;
            end else if (w_accept) begin
                r_o_data  <= in_data;
                r_o_valid <= 1'b1;
            end else begin
                r_o_valid <= 1'b0;
            end
        end else if (w_accept) begin
            // Output stalled: park the beat in the skid entry.
            r_s_data  <= in_data;
            r_s_valid <= 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/operand_mux_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : operand_mux_pipe
//  Description : Pipelined ALU operand-B select. Picks one of NUM_SRC
//                WIDTH-bit sources, flags out-of-range selects (data forced
//                to zero) and registers the beat through a skid buffer.
//  Ports       : clk, reset          - clock, synchronous active-high reset
//                in_data             - flattened sources, i at [i*WIDTH +: WIDTH]
//                in_sel              - source index
//                in_valid/in_ready   - upstream handshake
//                flush               - discard all held beats
//                out_data/out_err    - selected operand, out-of-range flag
//                out_valid/out_ready - downstream handshake
//  Revision    : 1.0 - initial release
// ============================================================================
module operand_mux_pipe
    import datapath_pkg::*;
#(
    parameter  int WIDTH   = OPERAND_W,
    parameter  int NUM_SRC = 4,
    localparam int SEL_W   = $clog2(NUM_SRC)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_SRC*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]         in_sel,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     flush,
    output logic [WIDTH-1:0]         out_data,
    output logic                     out_err,
    output logic                     out_valid,
    input  logic                     out_ready
);

    logic [WIDTH-1:0] w_sel_data;
    logic             w_sel_err;
    logic [WIDTH:0]   w_beat;
    logic [WIDTH:0]   w_out_beat;

    // Compare against every legal index so a non-power-of-two NUM_SRC never
    // reads past the end of in_data; unmatched selects leave zero.
    always_comb begin
        w_sel_data = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (int'(in_sel) == i) begin
                w_sel_data = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    assign w_sel_err = (int'(in_sel) >= NUM_SRC);
    assign w_beat    = {w_sel_err, w_sel_data};

    skid_buffer #(
        .DATA_W (WIDTH + 1)
    ) u_skid (
        .clk       (clk),
        .reset     (reset),
        .in_data   (w_beat),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .flush     (flush),
        .out_data  (w_out_beat),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    assign out_err  = w_out_beat[WIDTH];
    assign out_data = w_out_beat[WIDTH-1:0];

endmodule
`default_nettype wire

// File: tb/tb_operand_mux_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_operand_mux_pipe
//  Description : Self-checking bench for operand_mux_pipe. One instance with
//                NUM_SRC=4 and one with NUM_SRC=3 for the out-of-range path.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_operand_mux_pipe;
    import datapath_pkg::*;

    logic           clk;
    logic           reset;

    logic [255:0]   in_data4;
    logic [1:0]     in_sel4;
    logic           in_valid4;
    logic           in_ready4;
    logic           flush4;
    logic [63:0]    out_data4;
    logic           out_err4;
    logic           out_valid4;
    logic           out_ready4;

    logic [191:0]   in_data3;
    logic [1:0]     in_sel3;
    logic           in_valid3;
    logic           in_ready3;
    logic [63:0]    out_data3;
    logic           out_err3;
    logic           out_valid3;

    int checks;
    int errors;

    operand_mux_pipe #(.WIDTH(64), .NUM_SRC(4)) u_dut4 (
        .clk(clk), .reset(reset), .in_data(in_data4), .in_sel(in_sel4),
        .in_valid(in_valid4), .in_ready(in_ready4), .flush(flush4),
        .out_data(out_data4), .out_err(out_err4), .out_valid(out_valid4),
        .out_ready(out_ready4)
    );

    operand_mux_pipe #(.WIDTH(64), .NUM_SRC(3)) u_dut3 (
        .clk(clk), .reset(reset), .in_data(in_data3), .in_sel(in_sel3),
        .in_valid(in_valid3), .in_ready(in_ready3), .flush(1'b0),
        .out_data(out_data3), .out_err(out_err3), .out_valid(out_valid3),
        .out_ready(1'b1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        bit          on3;
        logic [1:0]  sel;
        logic [63:0] data;
        logic        err;
    } vec_t;

    vec_t vecs[8];

    localparam logic [255:0] SRC4 = {64'h4444, 64'h3333, 64'hFFFF_FFFF_FFFF_FFF0, 64'h1111};
    localparam logic [191:0] SRC3 = {64'hCCCC, 64'hBBBB, 64'hAAAA};

    initial begin
        logic [63:0] exp_q[$];
        logic [63:0] beat_exp;
        logic [63:0] got;
        int          sent;
        int          cycles;
        int          rcvd;
        bit          acc;
        bit          drn;

        checks = 0;
        errors = 0;

        vecs[0] = '{1'b0, 2'(SRC_IMM),       64'hFFFF_FFFF_FFFF_FFF0, 1'b0};
        vecs[1] = '{1'b0, 2'(SRC_REG),       64'h1111, 1'b0};
        vecs[2] = '{1'b0, 2'(SRC_FWD_EXMEM), 64'h3333, 1'b0};
        vecs[3] = '{1'b0, 2'(SRC_FWD_MEMWB), 64'h4444, 1'b0};
        vecs[4] = '{1'b1, 2'(SRC_REG),       64'hAAAA, 1'b0};
        vecs[5] = '{1'b1, 2'd3,              64'h0,    1'b1};
        vecs[6] = '{1'b1, 2'(SRC_FWD_EXMEM), 64'hCCCC, 1'b0};
        vecs[7] = '{1'b1, 2'(SRC_IMM),       64'hBBBB, 1'b0};

        reset      = 1'b1;
        in_data4   = SRC4;
        in_sel4    = '0;
        in_valid4  = 1'b0;
        flush4     = 1'b0;
        out_ready4 = 1'b1;
        in_data3   = SRC3;
        in_sel3    = '0;
        in_valid3  = 1'b0;

        // ---------------- reset state ----------------
        step();
        step();
        reset = 1'b0;
        chk("rst_out_valid", 64'(out_valid4), 64'd0);
        chk("rst_out_data",  out_data4,       64'd0);
        chk("rst_out_err",   64'(out_err4),   64'd0);
        chk("rst_in_ready",  64'(in_ready4),  64'd1);

        // ---------------- table-driven single beats ----------------
        for (int i = 0; i < 8; i++) begin
            in_valid4 = !vecs[i].on3;
            in_valid3 = vecs[i].on3;
            in_sel4   = vecs[i].sel;
            in_sel3   = vecs[i].sel;
            step();
            if (vecs[i].on3) begin
                chk($sformatf("vec%0d_valid", i), 64'(out_valid3), 64'd1);
                chk($sformatf("vec%0d_data", i),  out_data3,       vecs[i].data);
                chk($sformatf("vec%0d_err", i),   64'(out_err3),   64'(vecs[i].err));
            end else begin
                chk($sformatf("vec%0d_valid", i), 64'(out_valid4), 64'd1);
                chk($sformatf("vec%0d_data", i),  out_data4,       vecs[i].data);
                chk($sformatf("vec%0d_err", i),   64'(out_err4),   64'(vecs[i].err));
            end
        end
        in_valid4 = 1'b0;
        in_valid3 = 1'b0;
        step();
        chk("idle_out_valid", 64'(out_valid4), 64'd0);
        chk("idle_data_held", out_data4,       64'h4444);

        // ---------------- backpressure ----------------
        out_ready4 = 1'b0;
        in_valid4  = 1'b1;
        in_sel4    = 2'(SRC_REG);
        step();
        in_sel4    = 2'(SRC_FWD_EXMEM);
        step();
        chk("bp_in_ready_low", 64'(in_ready4), 64'd0);
        in_sel4    = 2'(SRC_FWD_MEMWB);
        step();
        chk("bp_hold_data",    out_data4,       64'h1111);
        chk("bp_hold_ready",   64'(in_ready4),  64'd0);
        step();
        chk("bp_stable_data",  out_data4,       64'h1111);
        out_ready4 = 1'b1;
        step();
        chk("bp_out2", out_data4, 64'h3333);
        step();
        in_valid4 = 1'b0;
        chk("bp_out3", out_data4, 64'h4444);
        chk("bp_out3_valid", 64'(out_valid4), 64'd1);
        step();
        chk("bp_empty", 64'(out_valid4), 64'd0);

        // ---------------- flush with O and S full ----------------
        out_ready4 = 1'b0;
        in_valid4  = 1'b1;
        in_sel4    = 2'(SRC_REG);
        step();
        in_sel4    = 2'(SRC_IMM);
        step();
        flush4     = 1'b1;
        in_sel4    = 2'(SRC_FWD_MEMWB);
        step();
        flush4     = 1'b0;
        in_valid4  = 1'b0;
        chk("fl_out_valid", 64'(out_valid4), 64'd0);
        chk("fl_in_ready",  64'(in_ready4),  64'd1);
        out_ready4 = 1'b1;
        step();
        chk("fl_nothing_left", 64'(out_valid4), 64'd0);

        // flush with O full, S empty and an acceptable beat in the same cycle
        out_ready4 = 1'b0;
        in_valid4  = 1'b1;
        in_sel4    = 2'(SRC_FWD_EXMEM);
        step();
        flush4     = 1'b1;
        in_sel4    = 2'(SRC_FWD_MEMWB);
        step();
        flush4     = 1'b0;
        in_valid4  = 1'b0;
        out_ready4 = 1'b1;
        chk("fl2_out_valid", 64'(out_valid4), 64'd0);
        step();
        chk("fl2_beat_dropped", 64'(out_valid4), 64'd0);

        // ---------------- reset mid-operation ----------------
        out_ready4 = 1'b0;
        in_valid4  = 1'b1;
        in_sel4    = 2'(SRC_FWD_EXMEM);
        step();
        in_sel4    = 2'(SRC_FWD_MEMWB);
        step();
        in_valid4  = 1'b0;
        reset      = 1'b1;
        step();
        reset      = 1'b0;
        chk("mr_out_valid", 64'(out_valid4), 64'd0);
        chk("mr_out_data",  out_data4,       64'd0);
        chk("mr_out_err",   64'(out_err4),   64'd0);
        chk("mr_in_ready",  64'(in_ready4),  64'd1);
        in_valid4  = 1'b1;
        in_sel4    = 2'(SRC_FWD_EXMEM);
        out_ready4 = 1'b1;
        step();
        in_valid4  = 1'b0;
        chk("mr_new_valid", 64'(out_valid4), 64'd1);
        chk("mr_new_data",  out_data4,       64'h3333);
        step();

        // ---------------- streaming: phase 0 full rate, phase 1 random ready
        for (int ph = 0; ph < 2; ph++) begin
            sent   = 0;
            rcvd   = 0;
            cycles = 0;
            exp_q.delete();
            in_data4 = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            in_sel4  = 2'($urandom_range(0, 3));
            while ((sent < 100 || exp_q.size() > 0) && cycles < 1000) begin
                in_valid4  = (sent < 100);
                out_ready4 = (ph == 0) ? 1'b1 : 1'($urandom_range(0, 1));
                acc = in_valid4 && in_ready4;
                drn = out_valid4 && out_ready4;
                beat_exp = in_data4[int'(in_sel4)*64 +: 64];
                if (drn) begin
                    rcvd++;
                    got = exp_q.size() > 0 ? exp_q.pop_front() : 64'hDEAD_DEAD_DEAD_DEAD;
                    if (out_data4 !== got || out_err4 !== 1'b0) begin
                        checks++;
                        errors++;
                        $display("FAIL stream%0d_beat%0d: got %h err %b expected %h err 0",
                                 ph, rcvd, out_data4, out_err4, got);
                    end
                end
                step();
                cycles++;
                if (acc) begin
                    exp_q.push_back(beat_exp);
                    sent++;
                    in_data4 = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
                    in_sel4  = 2'($urandom_range(0, 3));
                end
            end
            in_valid4 = 1'b0;
            chk($sformatf("stream%0d_received", ph), 64'(rcvd), 64'd100);
            chk($sformatf("stream%0d_sent", ph),     64'(sent), 64'd100);
            if (ph == 0) begin
                chk("stream0_cycles", 64'(cycles), 64'd101);
            end else begin
                chk("stream1_timeout", 64'(cycles < 1000), 64'd1);
            end
        end
        out_ready4 = 1'b1;
        step();
        chk("stream_drained", 64'(out_valid4), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
